// File: rtl/seq_mux.sv
// seq_mux: N-channel valid/ready multiplexer, static select or round-robin scan.
// Optional out_par parity output enabled by defining SEQ_MUX_PARITY_EN.
module seq_mux #(
    parameter int N = 4,
    parameter int W = 1,
    localparam int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    input  logic           mode,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sel_err
`ifdef SEQ_MUX_PARITY_EN
    ,
    output logic           out_par
`endif
);

    localparam logic [SW:0] NL   = (SW+1)'(N);
    localparam logic [SW:0] LAST = NL - 1'b1;

    logic          ld;
    logic          c_ok;
    logic [SW-1:0] c;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_nxt;
    logic [W-1:0]  c_data;
    logic          c_valid;

    assign ld = !out_valid || out_ready;

    // Candidate channel, range check and next scan position
    always_comb begin
        c       = mode ? ptr : sel;
        c_ok    = {1'b0, c} < NL;
        ptr_nxt = ({1'b0, ptr} == LAST) ? '0 : ptr + 1'b1;
    end

    // Gather the candidate channel's data/valid and grant its ready
    always_comb begin
        c_data   = '0;
        c_valid  = 1'b0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (c == SW'(i)) begin
                c_data      = in_data[i*W +: W];
                c_valid     = in_valid[i];
                in_ready[i] = rst_n && ld && c_ok;
            end
        end
    end

    // Output register, scan pointer and sticky select error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            sel_err   <= 1'b0;
        end else if (ld) begin
            if (c_ok) begin
                out_data  <= c_data;
                out_ch    <= c;
                out_valid <= c_valid;
            end else begin
                out_valid <= 1'b0;
                sel_err   <= 1'b1;
            end
            ptr <= mode ? ptr_nxt : '0;
        end
    end

`ifdef SEQ_MUX_PARITY_EN
    // Parity of the loaded word, tracking out_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_par <= 1'b0;
        end else if (ld && c_ok) begin
            out_par <= ^c_data;
        end
    end
`endif

endmodule

// File: tb/tb_seq_mux.sv
// tb_seq_mux: directed table plus hand sequences for stall, select error,
// async reset and (when SEQ_MUX_PARITY_EN is defined) parity.
module tb_seq_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [31:0] d4 = '0;
    logic [3:0]  iv4 = '0;
    logic [3:0]  rdy4;
    logic [1:0]  sel4 = '0;
    logic        md4 = 1'b0;
    logic [7:0]  od4;
    logic [1:0]  och4;
    logic        ov4;
    logic        ordy4 = 1'b1;
    logic        se4;

    logic [23:0] d3 = '0;
    logic [2:0]  iv3 = '0;
    logic [2:0]  rdy3;
    logic [1:0]  sel3 = '0;
    logic        md3 = 1'b0;
    logic [7:0]  od3;
    logic [1:0]  och3;
    logic        ov3;
    logic        ordy3 = 1'b1;
    logic        se3;

`ifdef SEQ_MUX_PARITY_EN
    logic        par4;
    logic        par3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mux #(.N(4), .W(8)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d4), .in_valid(iv4), .in_ready(rdy4),
        .sel(sel4), .mode(md4),
        .out_data(od4), .out_ch(och4), .out_valid(ov4),
        .out_ready(ordy4), .sel_err(se4)
`ifdef SEQ_MUX_PARITY_EN
        , .out_par(par4)
`endif
    );

    seq_mux #(.N(3), .W(8)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3), .in_valid(iv3), .in_ready(rdy3),
        .sel(sel3), .mode(md3),
        .out_data(od3), .out_ch(och3), .out_valid(ov3),
        .out_ready(ordy3), .sel_err(se3)
`ifdef SEQ_MUX_PARITY_EN
        , .out_par(par3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        md;
        logic [1:0]  sl;
        logic [3:0]  iv;
        logic [31:0] d;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  ch;
        logic [7:0]  dat;
    } vec_t;

    vec_t tv [16];

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1'b0, 2'd2, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
        tv[1]  = '{1'b0, 2'd2, 4'b0100, 32'h003C0000, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
        tv[2]  = '{1'b0, 2'd2, 4'b0100, 32'h003C0000, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
        tv[3]  = '{1'b0, 2'd2, 4'b0100, 32'h003C0000, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5};
        tv[4]  = '{1'b0, 2'd2, 4'b0100, 32'h003C0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h3C};
        tv[5]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tv[6]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tv[7]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
        tv[8]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
        tv[9]  = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
        tv[10] = '{1'b1, 2'd0, 4'b1101, 32'h13121110, 1'b1, 4'b0010, 1'b0, 2'd1, 8'h11};
        tv[11] = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h12};
        tv[12] = '{1'b1, 2'd0, 4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
        tv[13] = '{1'b0, 2'd1, 4'b1111, 32'h13121110, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
        tv[14] = '{1'b0, 2'd1, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        tv[15] = '{1'b1, 2'd1, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};

        // Reset asserted with no clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ov", 32'(ov4), 32'h0);
        chk("rst_data", 32'(od4), 32'h0);
        chk("rst_ch", 32'(och4), 32'h0);
        chk("rst_err", 32'(se4), 32'h0);
        chk("rst_rdy", 32'(rdy4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            md4 = tv[i].md;
            sel4 = tv[i].sl;
            iv4 = tv[i].iv;
            d4 = tv[i].d;
            ordy4 = tv[i].ordy;
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(rdy4), 32'(tv[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ov", i), 32'(ov4), 32'(tv[i].ov));
            chk($sformatf("v%0d_ch", i), 32'(och4), 32'(tv[i].ch));
            chk($sformatf("v%0d_dat", i), 32'(od4), 32'(tv[i].dat));
        end

        // Select error on a 3-channel instance
        @(negedge clk);
        sel3 = 2'd1;
        d3 = 24'h005500;
        iv3 = 3'b111;
        #1 chk("e_rdy1", 32'(rdy3), 32'h2);
        @(posedge clk);
        #1;
        chk("e_ov1", 32'(ov3), 32'h1);
        chk("e_ch1", 32'(och3), 32'h1);
        chk("e_dat1", 32'(od3), 32'h55);
        chk("e_err1", 32'(se3), 32'h0);
        @(negedge clk);
        sel3 = 2'd3;
        #1 chk("e_rdy3", 32'(rdy3), 32'h0);
        @(posedge clk);
        #1;
        chk("e_ov3", 32'(ov3), 32'h0);
        chk("e_ch3", 32'(och3), 32'h1);
        chk("e_dat3", 32'(od3), 32'h55);
        chk("e_err3", 32'(se3), 32'h1);
        @(negedge clk);
        sel3 = 2'd0;
        d3 = 24'h000022;
        @(posedge clk);
        #1;
        chk("e_ov0", 32'(ov3), 32'h1);
        chk("e_ch0", 32'(och3), 32'h0);
        chk("e_dat0", 32'(od3), 32'h22);
        chk("e_err0", 32'(se3), 32'h1);
        @(posedge clk);
        #1 chk("e_sticky", 32'(se3), 32'h1);

        // Async reset in the middle of a stall
        @(negedge clk);
        ordy4 = 1'b0;
        @(posedge clk);
        #1;
        chk("s_ov", 32'(ov4), 32'h1);
        chk("s_dat", 32'(od4), 32'h10);
        #2 rst_n = 1'b0;
        ordy4 = 1'b1;
        #1;
        chk("a_ov", 32'(ov4), 32'h0);
        chk("a_dat", 32'(od4), 32'h0);
        chk("a_ch", 32'(och4), 32'h0);
        chk("a_err3", 32'(se3), 32'h0);
        chk("a_rdy", 32'(rdy4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("r_rdy", 32'(rdy4), 32'h1);
        @(posedge clk);
        #1;
        chk("r_ch0", 32'(och4), 32'h0);
        chk("r_dat0", 32'(od4), 32'h10);
        chk("r_ov0", 32'(ov4), 32'h1);
        @(posedge clk);
        #1;
        chk("r_ch1", 32'(och4), 32'h1);
        chk("r_dat1", 32'(od4), 32'h11);

`ifdef SEQ_MUX_PARITY_EN
        @(negedge clk);
        md4 = 1'b0;
        sel4 = 2'd0;
        d4 = 32'h00000007;
        @(posedge clk);
        #1 chk("par07", 32'(par4), 32'h1);
        @(negedge clk);
        d4 = 32'h00000003;
        @(posedge clk);
        #1 chk("par03", 32'(par4), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_mux.md
SEQ_MUX -- requirements
Module: seq_mux

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default 1: data width per channel, legal range 1..32.
REQ-003 SHALL derive localparam SW = max(1, clog2(N)) as the select/pointer width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_data, input, N*W: channel i occupies bits [i*W +: W].
REQ-007 SHALL have port in_valid, input, N: per-channel valid.
REQ-008 SHALL have port in_ready, output, N: per-channel ready, combinational, at most one bit high.
REQ-009 SHALL have port sel, input, SW: channel select in static mode.
REQ-010 SHALL have port mode, input, 1: 0 = static select, 1 = round-robin scan.
REQ-011 SHALL have port out_data, output, W: registered selected data.
REQ-012 SHALL have port out_ch, output, SW: index of the channel that produced out_data.
REQ-013 SHALL have port out_valid, output, 1: out_data/out_ch hold a transfer.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts when high with out_valid.
REQ-015 SHALL have port sel_err, output, 1: sticky flag, static-mode select out of range.

Function
REQ-016 SHALL define load enable ld = !out_valid || out_ready.
REQ-017 SHALL define the candidate channel c = sel when mode=0, c = ptr when mode=1; ptr is an internal SW-bit scan pointer.
REQ-018 SHALL drive in_ready[c] = ld and all other in_ready bits 0; when mode=0 and sel >= N, all in_ready SHALL be 0.
REQ-019 SHALL, on a rising edge with ld=1 and c < N, load out_data <= channel c data, out_ch <= c, out_valid <= in_valid[c]; latency input-to-output is exactly one cycle.
REQ-020 SHALL, on a rising edge with ld=0 (out_valid=1, out_ready=0), hold out_data, out_ch, out_valid, and ptr unchanged.
REQ-021 SHALL, in mode=1, advance ptr on every edge with ld=1, ptr <= (ptr == N-1) ? 0 : ptr+1, regardless of in_valid[ptr].
REQ-022 SHALL force ptr <= 0 on every edge with mode=0, so entering scan mode always starts at channel 0.
REQ-023 SHALL, in mode=0 with sel >= N and ld=1, load out_valid <= 0, hold out_data/out_ch, and set sel_err <= 1.
REQ-024 SHALL clear sel_err only by reset.
REQ-025 SHALL apply a mode or sel change at the next edge with ld=1; a stalled output transfer SHALL never be altered.

Reset
REQ-026 SHALL, while rst_n=0, force out_data=0, out_ch=0, out_valid=0, ptr=0, sel_err=0 immediately (asynchronously).
REQ-027 SHALL, with rst_n=0, drive in_ready=0 on all channels.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-stall SHALL discard the stalled transfer.

Configuration
REQ-029 SHALL, when macro SEQ_MUX_PARITY_EN is defined, add output port out_par (1 bit) registered with out_data as the XOR reduction of the loaded channel data, reset to 0, held during stall.
REQ-030 SHALL, when SEQ_MUX_PARITY_EN is undefined, omit out_par entirely with all other behaviour identical.

Verification
REQ-031 Static: N=4, W=8, mode=0, sel=2, in_data ch2=0xA5, in_valid=4'b0100, out_ready=1 -> next cycle out_data=0xA5, out_ch=2, out_valid=1, in_ready=4'b0100.
REQ-032 Stall: out_valid=1, out_ready=0 for 3 cycles while ch2 data changes to 0x3C -> out_data stays 0xA5, in_ready=0; out_ready=1 -> 0x3C loads next cycle.
REQ-033 Scan wrap: mode=1, all in_valid=1, ch0..3=0x10,0x11,0x12,0x13, out_ready=1 -> out_ch sequence 0,1,2,3,0 with matching data; in_valid[1]=0 -> out_valid=0 in ch1's slot, ptr still advances.
REQ-034 Select error: N=3, mode=0, sel=3 -> out_valid=0, sel_err=1, stays 1 after sel=0; cleared only by rst_n=0.
REQ-035 Async reset mid-stall: rst_n=0 between edges -> out_valid, out_data, sel_err go 0 without a clk edge; after release, mode=1 starts at out_ch=0.
REQ-036 Parity (SEQ_MUX_PARITY_EN defined): ch0=0x07 selected -> out_par=1; ch0=0x03 -> out_par=0.
